// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register numbers, exception codes and SR/Cause bit positions
package cp0_pkg;
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_SR       = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int SR_IE     = 0;
    localparam int SR_EXL    = 1;
    localparam int SR_IM_LO  = 10;
    localparam int CAUSE_TI  = 30;
    localparam int CAUSE_BD  = 31;

    // IM[15:10], EXL and IE are the only storage bits in SR
    localparam logic [31:0] SR_MASK = 32'h0000_FC03;
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer with sticky TI
//   clk, reset     clock, async active-high reset
//   count_we       load Count from wdata instead of incrementing
//   compare_we     load Compare from wdata and clear TI
//   wdata          load data
//   count, compare registered values; ti sticky timer interrupt
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic        ti_q, ti_d;

    always_comb begin
        count_d   = count_we ? wdata : count_q + 32'd1;
        compare_d = compare_we ? wdata : compare_q;
        // a Compare write clears TI even when the match fires on the same edge
        ti_d      = !compare_we & (ti_q | (count_q == compare_q));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= 32'd0;
            compare_q <= 32'hFFFF_FFFF;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;
endmodule

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: MIPS CP0 with SR/Cause/EPC/PRId/BadVAddr/Count/Compare and exception arbitration
//   clk, reset                  clock, async active-high reset
//   we, wr_addr, wdata          mtc0 write port
//   rd_addr, rdata              mfc0 read port (combinational, registered values)
//   pc, in_delay_slot           victim instruction in M
//   exc_code, bad_vaddr         synchronous exception code (0 = none) and faulting address
//   hw_int                      level-sensitive IRQ lines, line i -> Cause.IP[10+i]
//   eret                        eret in M
//   int_req                     take exception this cycle
//   epc                         eret return address (bypasses a same-cycle mtc0 EPC)
//   timer_irq                   Cause.TI
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter int          NUM_HWINT = 6,
    parameter bit          TIMER_EN  = 1'b1,
    parameter logic [31:0] PRID_VAL  = 32'h1998_0107
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [4:0]           wr_addr,
    input  logic [31:0]          wdata,
    input  logic [4:0]           rd_addr,
    output logic [31:0]          rdata,
    input  logic [31:0]          pc,
    input  logic                 in_delay_slot,
    input  logic [4:0]           exc_code,
    input  logic [31:0]          bad_vaddr,
    input  logic [NUM_HWINT-1:0] hw_int,
    input  logic                 eret,
    output logic                 int_req,
    output logic [31:0]          epc,
    output logic                 timer_irq
);
    logic [31:0] sr_q, sr_d, epc_q, epc_d, bad_q, bad_d;
    logic [4:0]  code_q, code_d, taken_code;
    logic        bd_q, bd_d;
    logic [31:0] count, compare;
    logic        ti, int_term, wr_sr, wr_epc;
    logic [5:0]  ip;

    assign ip         = 6'(hw_int) | {ti, 5'b0};
    assign int_term   = (|(ip & sr_q[15:10])) & sr_q[SR_IE];
    assign int_req    = !reset & !sr_q[SR_EXL] & (int_term | (exc_code != EXC_INT));
    // an interrupt takes precedence over a coincident synchronous exception
    assign taken_code = int_term ? EXC_INT : exc_code;
    assign wr_sr      = we & (wr_addr == REG_SR);
    assign wr_epc     = we & (wr_addr == REG_EPC);
    assign epc        = wr_epc ? wdata : epc_q;
    assign timer_irq  = ti;

    generate
        if (TIMER_EN) begin : g_timer
            cp0_timer u_timer (
                .clk        (clk),
                .reset      (reset),
                .count_we   (we & (wr_addr == REG_COUNT) & !int_req),
                .compare_we (we & (wr_addr == REG_COMPARE) & !int_req),
                .wdata      (wdata),
                .count      (count),
                .compare    (compare),
                .ti         (ti)
            );
        end else begin : g_no_timer
            assign count   = 32'd0;
            assign compare = 32'd0;
            assign ti      = 1'b0;
        end
    endgenerate

    always_comb begin
        sr_d          = wr_sr ? (wdata & SR_MASK) : sr_q;
        sr_d[SR_EXL]  = sr_d[SR_EXL] & !eret;
        epc_d         = wr_epc ? wdata : epc_q;
        bd_d          = bd_q;
        code_d        = code_q;
        bad_d         = bad_q;
        // entry discards any coincident mtc0 and eret
        if (int_req) begin
            sr_d         = sr_q;
            sr_d[SR_EXL] = 1'b1;
            epc_d        = in_delay_slot ? pc - 32'd4 : pc;
            bd_d         = in_delay_slot;
            code_d       = taken_code;
            bad_d        = (taken_code == EXC_ADEL || taken_code == EXC_ADES) ? bad_vaddr : bad_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q   <= 32'd0;
            epc_q  <= 32'd0;
            bad_q  <= 32'd0;
            code_q <= 5'd0;
            bd_q   <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            epc_q  <= epc_d;
            bad_q  <= bad_d;
            code_q <= code_d;
            bd_q   <= bd_d;
        end
    end

    always_comb begin
        case (rd_addr)
            REG_SR:       rdata = sr_q;
            REG_CAUSE:    rdata = {bd_q, ti, 14'd0, ip, 3'd0, code_q, 2'd0};
            REG_EPC:      rdata = epc_q;
            REG_PRID:     rdata = PRID_VAL;
            REG_BADVADDR: rdata = bad_q;
            REG_COUNT:    rdata = count;
            REG_COMPARE:  rdata = compare;
            default:      rdata = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_cp0_ctrl.sv
// tb_cp0_ctrl: directed plus randomized check of cp0_ctrl against a register-level model
module tb_cp0_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  rd_addr = '0;
    logic [31:0] rdata;
    logic [31:0] pc = '0;
    logic        in_delay_slot = 1'b0;
    logic [4:0]  exc_code = '0;
    logic [31:0] bad_vaddr = '0;
    logic [5:0]  hw_int = '0;
    logic        eret = 1'b0;
    logic        int_req;
    logic [31:0] epc;
    logic        timer_irq;

    int errors = 0;
    int checks = 0;

    cp0_ctrl #(.NUM_HWINT(6), .TIMER_EN(1'b1), .PRID_VAL(32'h1998_0107)) dut (
        .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wdata(wdata),
        .rd_addr(rd_addr), .rdata(rdata), .pc(pc), .in_delay_slot(in_delay_slot),
        .exc_code(exc_code), .bad_vaddr(bad_vaddr), .hw_int(hw_int), .eret(eret),
        .int_req(int_req), .epc(epc), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    // architectural state of the model
    logic [31:0] m_sr, m_epc, m_bad, m_cnt, m_cmp;
    logic [4:0]  m_code;
    logic        m_bd, m_ti;

    task automatic m_reset();
        m_sr = 0; m_epc = 0; m_bad = 0; m_cnt = 0; m_cmp = 32'hFFFF_FFFF;
        m_code = 0; m_bd = 0; m_ti = 0;
    endtask

    function automatic logic [31:0] m_ip();
        return (32'(hw_int) << 10) | (m_ti ? 32'h0000_8000 : 32'h0);
    endfunction

    function automatic logic m_int();
        return ((m_ip() & m_sr & 32'h0000_FC00) != 0) && m_sr[0];
    endfunction

    function automatic logic m_req();
        if (reset || m_sr[1]) return 1'b0;
        return m_int() || (exc_code != 0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12: return m_sr;
            5'd13: return (32'(m_bd) << 31) | (32'(m_ti) << 30) | m_ip() | (32'(m_code) << 2);
            5'd14: return m_epc;
            5'd15: return 32'h1998_0107;
            5'd8:  return m_bad;
            5'd9:  return m_cnt;
            5'd11: return m_cmp;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_update();
        logic        req, hit;
        logic [4:0]  code;
        if (reset) begin
            m_reset();
            return;
        end
        req = m_req();
        hit = (m_cnt == m_cmp);
        m_cnt = (!req && we && wr_addr == 9) ? wdata : m_cnt + 1;
        if (!req && we && wr_addr == 11) begin
            m_cmp = wdata;
            m_ti = 0;
        end else if (hit) m_ti = 1;
        if (req) begin
            code = m_int() ? 5'd0 : exc_code;
            m_epc = in_delay_slot ? pc - 4 : pc;
            m_bd = in_delay_slot;
            m_code = code;
            m_sr = m_sr | 32'h2;
            if (code == 4 || code == 5) m_bad = bad_vaddr;
        end else begin
            if (we && wr_addr == 12) m_sr = wdata & 32'h0000_FC03;
            if (we && wr_addr == 14) m_epc = wdata;
            if (eret) m_sr = m_sr & ~32'h2;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // compare everything against the model, then advance one clock
    task automatic cyc();
        #1;
        chk("int_req", 32'(int_req), 32'(m_req()));
        chk("rdata", rdata, m_read(rd_addr));
        chk("epc", epc, (we && wr_addr == 14) ? wdata : m_epc);
        chk("timer_irq", 32'(timer_irq), 32'(m_ti));
        @(posedge clk);
        m_update();
        @(negedge clk);
    endtask

    task automatic idle();
        we = 0; wr_addr = 0; wdata = 0; exc_code = 0; eret = 0;
        in_delay_slot = 0; hw_int = 0; bad_vaddr = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle(); we = 1; wr_addr = a; wdata = d; cyc(); idle();
    endtask

    initial begin
        logic [4:0] addr_tab [8];
        logic [4:0] exc_tab [4];
        addr_tab = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
        exc_tab  = '{5'd4, 5'd5, 5'd10, 5'd12};
        m_reset();
        @(negedge clk);
        rd_addr = 11; #1;
        chk("reset_int_req", 32'(int_req), 32'h0);
        chk("reset_compare", rdata, 32'hFFFF_FFFF);
        @(negedge clk);
        reset = 0;
        rd_addr = 12;
        cyc();

        // 1: hardware interrupt entry
        mtc0(12, 32'h0000_FC01);
        hw_int = 6'b000100; pc = 32'h0000_1000; #1;
        chk("t1_req", 32'(int_req), 32'h1);
        cyc();
        rd_addr = 14; #1;
        chk("t1_epc", rdata, 32'h0000_1000);
        chk("t1_req_after", 32'(int_req), 32'h0);
        rd_addr = 13; #1;
        chk("t1_cause", rdata, 32'h0000_1000);
        rd_addr = 12;
        cyc();
        idle(); eret = 1; cyc(); idle();

        // 2: synchronous exception in a delay slot
        exc_code = 12; in_delay_slot = 1; pc = 32'h0000_3010; #1;
        chk("t2_req", 32'(int_req), 32'h1);
        cyc(); idle();
        rd_addr = 14; #1;
        chk("t2_epc", rdata, 32'h0000_300C);
        rd_addr = 13; #1;
        chk("t2_bd", 32'(rdata[31]), 32'h1);
        chk("t2_code", 32'(rdata[6:2]), 32'd12);
        cyc();
        eret = 1; cyc(); idle();

        // 3: AdEL with masked IRQ, then with the IRQ enabled
        mtc0(12, 32'h0000_F801);
        hw_int = 6'b000001; exc_code = 4; bad_vaddr = 32'h0000_0003; #1;
        chk("t3_req", 32'(int_req), 32'h1);
        cyc(); idle();
        rd_addr = 13; #1;
        chk("t3_code", 32'(rdata[6:2]), 32'd4);
        rd_addr = 8; #1;
        chk("t3_bad", rdata, 32'h0000_0003);
        eret = 1; cyc(); idle();
        mtc0(12, 32'h0000_FC01);
        hw_int = 6'b000001; exc_code = 4; bad_vaddr = 32'h0000_0077;
        cyc(); idle();
        rd_addr = 13; #1;
        chk("t3_code_int", 32'(rdata[6:2]), 32'd0);
        rd_addr = 8; #1;
        chk("t3_bad_kept", rdata, 32'h0000_0003);
        eret = 1; cyc(); idle();

        // 4: Count/Compare timer
        mtc0(12, 32'h0000_8001);
        mtc0(11, 32'd10);
        mtc0(9, 32'd0);
        rd_addr = 9;
        repeat (10) cyc();
        #1;
        chk("t4_count", rdata, 32'd10);
        chk("t4_ti_before", 32'(timer_irq), 32'h0);
        cyc();
        #1;
        chk("t4_ti", 32'(timer_irq), 32'h1);
        chk("t4_req", 32'(int_req), 32'h1);
        cyc();
        we = 1; wr_addr = 11; wdata = 32'hFFFF_FFFF; #1;
        chk("t4_req_exl", 32'(int_req), 32'h0);
        cyc(); idle(); #1;
        chk("t4_ti_clear", 32'(timer_irq), 32'h0);
        eret = 1; cyc(); idle();

        // 5: eret with EPC bypass
        exc_code = 10; cyc(); idle();
        we = 1; wr_addr = 14; wdata = 32'h0000_4000; eret = 1; #1;
        chk("t5_epc_bypass", epc, 32'h0000_4000);
        cyc(); idle();
        rd_addr = 12; #1;
        chk("t5_exl", 32'(rdata[1]), 32'h0);

        // 6: asynchronous reset during a pending request
        exc_code = 12; #1;
        chk("t6_req", 32'(int_req), 32'h1);
        #1 reset = 1;
        m_reset();
        #1;
        chk("t6_req_reset", 32'(int_req), 32'h0);
        chk("t6_sr", rdata, 32'h0);
        rd_addr = 11; #1;
        chk("t6_compare", rdata, 32'hFFFF_FFFF);
        @(negedge clk);
        cyc();
        reset = 0; idle();
        cyc();

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            we = ($urandom % 2) == 0;
            wr_addr = ($urandom % 8 == 7) ? 5'($urandom) : addr_tab[$urandom % 8];
            wdata = ($urandom % 3 == 0) ? 32'($urandom % 40) : $urandom;
            rd_addr = ($urandom % 8 == 7) ? 5'($urandom) : addr_tab[$urandom % 8];
            pc = {$urandom, 2'b00} >> 2 << 2;
            in_delay_slot = $urandom % 2;
            exc_code = ($urandom % 5 == 0) ? exc_tab[$urandom % 4] : 5'd0;
            bad_vaddr = $urandom;
            hw_int = ($urandom % 4 == 0) ? 6'($urandom) : 6'd0;
            eret = ($urandom % 4) == 0;
            if ($urandom % 400 == 0) begin
                reset = 1;
                m_reset();
            end else reset = 0;
            cyc();
        end
        reset = 0; idle();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
